// File: rtl/result_pkg.sv
// Shared types and helpers for the result collection stage.
// Statistics counters are built only when RESULT_STATS_EN is defined.
package result_pkg;

    localparam int STAT_W = 8;
    localparam int RES_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE,
        ERR
    } collect_state_t;

    typedef struct packed {
        logic             ovf;
        logic [RES_W-1:0] data;
    } result_entry_t;

    function automatic logic [STAT_W-1:0] sat_inc(
        input logic [STAT_W-1:0] v
    );
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with flush; a push into a full FIFO
// is accepted when a pop happens on the same cycle.
module sync_fifo #(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    assign empty  = (r_count == '0);
    assign full   = (r_count == CW'(DEPTH));
    assign count  = r_count;
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    // Head reads as zero when empty so the output is defined after reset
    assign rdata  = empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush)
            r_mem[r_wptr] <= wdata;
    end

endmodule

// File: rtl/result_collector.sv
// Frames core results per start run and queues them for a consumer.
// RESULT_STATS_EN enables the per-frame overflow and drop counters.
module result_collector
    import result_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    parameter  int FRAME_LEN  = 20,
    localparam int CW         = $clog2(DEPTH + 1),
    localparam int FW         = $clog2(FRAME_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_overflow,
    input  logic                  in_error,
    output logic                  out_valid,
    output logic [DATA_WIDTH:0]   out_data,
    input  logic                  out_ready,
    output logic [CW-1:0]         count,
    output logic                  frame_done,
    output logic                  err,
    output logic [STAT_W-1:0]     ovf_cnt,
    output logic [STAT_W-1:0]     drop_cnt
);

    collect_state_t r_state;
    logic [FW-1:0]  r_frame_cnt;
    logic           r_frame_done;
    logic           r_err;

    logic           w_empty;
    logic           w_full;
    logic           w_run;
    logic           w_err_hit;
    logic           w_restart;
    logic           w_collect;
    logic           w_attempt;
    logic           w_pop;
    logic           w_accept;
    logic           w_last;
    logic [FW-1:0]  w_base_cnt;
    logic [FW-1:0]  w_next_cnt;

    assign w_run      = (r_state == COLLECT) || (r_state == DONE);
    assign w_err_hit  = in_error && w_run;
    // Error wins over a coincident start; a start in a run opens a new frame
    assign w_restart  = start && w_run && !w_err_hit;
    assign w_collect  = !w_err_hit && ((r_state == COLLECT) || w_restart);
    assign w_attempt  = in_valid && w_collect;
    assign w_pop      = out_valid && out_ready;
    assign w_accept   = w_attempt && (!w_full || w_pop);
    assign w_base_cnt = w_restart ? '0 : r_frame_cnt;
    assign w_next_cnt = w_base_cnt + FW'(w_attempt);
    assign w_last     = w_attempt && (w_next_cnt == FW'(FRAME_LEN));

    assign out_valid  = !w_empty && (r_state != ERR);
    assign frame_done = r_frame_done;
    assign err        = r_err;

    sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_accept),
        .pop   (w_pop),
        .flush (w_err_hit),
        .wdata ({in_overflow, in_data}),
        .rdata (out_data),
        .full  (w_full),
        .empty (w_empty),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_frame_cnt  <= '0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_frame_done <= w_last;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= COLLECT;
                        r_frame_cnt <= '0;
                    end
                end
                COLLECT, DONE: begin
                    if (w_err_hit) begin
                        r_state <= ERR;
                        r_err   <= 1'b1;
                    end else if (w_collect) begin
                        r_frame_cnt <= w_next_cnt;
                        r_state     <= w_last ? DONE : COLLECT;
                    end
                end
                ERR: begin
                    if (start) begin
                        r_state     <= COLLECT;
                        r_err       <= 1'b0;
                        r_frame_cnt <= '0;
                    end
                end
            endcase
        end
    end

`ifdef RESULT_STATS_EN
    logic [STAT_W-1:0] r_ovf;
    logic [STAT_W-1:0] r_drop;
    logic [STAT_W-1:0] w_ovf_base;
    logic [STAT_W-1:0] w_drop_base;
    logic              w_clear;
    logic              w_drop;

    assign w_clear     = start && !w_err_hit;
    assign w_ovf_base  = w_clear ? '0 : r_ovf;
    assign w_drop_base = w_clear ? '0 : r_drop;
    // Attempts after the frame has completed are counted as drops
    assign w_drop      = (w_attempt && !w_accept) ||
                         (in_valid && (r_state == DONE) && !start && !w_err_hit);
    assign ovf_cnt     = r_ovf;
    assign drop_cnt    = r_drop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf  <= '0;
            r_drop <= '0;
        end else begin
            r_ovf  <= (w_accept && in_overflow) ? sat_inc(w_ovf_base) : w_ovf_base;
            r_drop <= w_drop ? sat_inc(w_drop_base) : w_drop_base;
        end
    end
`else
    assign ovf_cnt  = '0;
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector with a queue-based reference model.
module tb_result_collector;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int FL    = 20;

    localparam int M_IDLE = 0;
    localparam int M_COL  = 1;
    localparam int M_DONE = 2;
    localparam int M_ERR  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_overflow = 1'b0;
    logic          in_error = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [DW:0]   out_data;
    logic [4:0]    count;
    logic          frame_done;
    logic          err;
    logic [7:0]    ovf_cnt;
    logic [7:0]    drop_cnt;

    result_collector #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .FRAME_LEN  (FL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_overflow (in_overflow),
        .in_error    (in_error),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .count       (count),
        .frame_done  (frame_done),
        .err         (err),
        .ovf_cnt     (ovf_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [DW:0] sb[$];
    logic [DW:0] mq[$];
    int          ms = M_IDLE;
    int          fc = 0;
    int          m_ovf = 0;
    int          m_drop = 0;
    bit          m_err = 0;
    bit          m_fd = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    // Monitor: compares the head against the scoreboard and pops on handshake
    always @(negedge clk) begin
        if (rst) begin
            chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            if (out_valid && sb.size() != 0)
                chk("out_data", 32'(out_data), 32'(sb[0]));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_read: got %0h expected none", out_data);
                end else begin
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic check_outs();
        chk("count", 32'(count), 32'(mq.size()));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("err", 32'(err), 32'(m_err));
`ifdef RESULT_STATS_EN
        chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`else
        chk("ovf_cnt", 32'(ovf_cnt), 32'd0);
        chk("drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    endtask

    // One clock of stimulus; called at posedge+1, returns at next posedge+1
    task automatic step(bit st, bit v, logic [DW-1:0] d, bit o, bit e, bit rdy);
        bit rd;
        bit fl;
        bit wr;
        start       = st;
        in_valid    = v;
        in_data     = d;
        in_overflow = o;
        in_error    = e;
        out_ready   = rdy;
        rd   = rdy && mq.size() > 0 && ms != M_ERR;
        fl   = 0;
        wr   = 0;
        m_fd = 0;
        if (e && (ms == M_COL || ms == M_DONE)) begin
            fl    = 1;
            ms    = M_ERR;
            m_err = 1;
        end else begin
            if (ms == M_IDLE || ms == M_ERR) begin
                if (st) begin
                    ms = M_COL; fc = 0; m_ovf = 0; m_drop = 0; m_err = 0;
                end
            end else begin
                if (st) begin
                    ms = M_COL; fc = 0; m_ovf = 0; m_drop = 0;
                end
                if (ms == M_COL && v) begin
                    fc++;
                    if (mq.size() < DEPTH || rd) begin
                        wr = 1;
                        if (o) m_ovf = sat(m_ovf);
                    end else begin
                        m_drop = sat(m_drop);
                    end
                    if (fc == FL) begin
                        ms   = M_DONE;
                        m_fd = 1;
                    end
                end else if (ms == M_DONE && v) begin
                    m_drop = sat(m_drop);
                end
            end
        end
        @(posedge clk);
        #1;
        if (rd) void'(mq.pop_front());
        if (fl) begin
            mq.delete();
            sb.delete();
        end
        if (wr) begin
            mq.push_back({o, d});
            sb.push_back({o, d});
        end
        check_outs();
    endtask

    task automatic idle(int n, bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, rdy);
    endtask

    initial begin
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // IDLE ignores writes
        for (int i = 0; i < 3; i++) step(0, 1, 8'($urandom), 0, 0, 1);

        // Full-rate frame, third value 0x80 with overflow
        step(1, 0, '0, 0, 0, 1);
        for (int i = 0; i < FL; i++)
            step(0, 1, (i == 2) ? 8'h80 : 8'($urandom), (i == 2), 0, 1);
        idle(4, 1);

        // Stalled consumer: FIFO fills and the tail is dropped
        step(1, 0, '0, 0, 0, 0);
        for (int i = 0; i < FL; i++)
            step(0, 1, 8'($urandom), 1'($urandom), 0, 0);
        idle(2, 0);
        // New frame while full with a same-cycle read
        step(1, 1, 8'($urandom), 1, 0, 1);
        idle(DEPTH + 3, 1);

        // Error after five writes flushes and locks out writes
        step(1, 0, '0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 8'($urandom), 0, 0, 0);
        step(0, 1, 8'($urandom), 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'($urandom), 0, 0, 1);
        step(1, 0, '0, 0, 0, 1);
        idle(2, 1);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            bit st;
            bit e;
            bit v;
            st = ($urandom_range(0, 29) == 0);
            e  = !st && ($urandom_range(0, 59) == 0);
            v  = ($urandom_range(0, 3) != 0);
            if (st && ms != M_COL) v = 0;
            step(st, v, 8'($urandom), 1'($urandom), e, ($urandom_range(0, 2) != 0));
        end

        // Asynchronous reset in the middle of a frame
        step(1, 0, '0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 8'($urandom), 1, 0, 0);
        #2;
        rst = 1'b0;
        start = 0; in_valid = 0; in_error = 0; out_ready = 0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_ovf_cnt", 32'(ovf_cnt), 32'd0);
        chk("arst_drop_cnt", 32'(drop_cnt), 32'd0);
        mq.delete();
        sb.delete();
        ms = M_IDLE; fc = 0; m_ovf = 0; m_drop = 0; m_err = 0; m_fd = 0;
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(0, 1, 8'($urandom), 0, 0, 1);
        step(1, 0, '0, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 1, 8'($urandom), 1'($urandom), 0, 1);
        idle(4, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
